// File: rtl/alu_ctrl_pipe.sv
// alu_ctrl_pipe: registered ALU control decode with multi-cycle multiply sequencing
module alu_ctrl_pipe #(
    parameter int FUNCT_W    = 6,
    parameter int OP_W       = 3,
    parameter int CTRL_W     = 4,
    parameter int MUL_CYCLES = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [FUNCT_W-1:0] funct_i,
    input  logic [OP_W-1:0]    ALUOp_i,
    input  logic               stall_i,
    input  logic               flush_i,
    output logic [CTRL_W-1:0]  ALUCtrl_o,
    output logic               valid_o,
    output logic               shamt_sel_o,
    output logic               jr_o,
    output logic               illegal_o,
    output logic               mul_step_o,
    output logic               busy_o
);
    localparam int CNT_W = $clog2(MUL_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_CYCLES - 1);
    localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010, C_SLL = 4'b0011,
                           C_SRL = 4'b0100, C_SRA = 4'b0101, C_SUB = 4'b0110, C_SLT = 4'b0111,
                           C_LUI = 4'b1000, C_MUL = 4'b1001, C_SLTU = 4'b1010, C_NOR = 4'b1100;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       w_code;
    logic             w_shamt;
    logic             w_jr;
    logic             w_ill;
    logic             w_mul;

    assign ready_o = !stall_i && r_state != RUN;
    assign w_mul   = w_code == C_MUL;

    // decode ALUOp/funct into the extended control code and side flags
    always_comb begin
        w_code  = C_AND;
        w_shamt = 1'b0;
        w_jr    = 1'b0;
        w_ill   = 1'b0;
        if (ALUOp_i == '0) begin
            case (funct_i)
                FUNCT_W'(32), FUNCT_W'(33): w_code = C_ADD;
                FUNCT_W'(34), FUNCT_W'(35): w_code = C_SUB;
                FUNCT_W'(36):               w_code = C_AND;
                FUNCT_W'(37):               w_code = C_OR;
                FUNCT_W'(39):               w_code = C_NOR;
                FUNCT_W'(42):               w_code = C_SLT;
                FUNCT_W'(43):               w_code = C_SLTU;
                FUNCT_W'(0):  begin w_code = C_SLL; w_shamt = 1'b1; end
                FUNCT_W'(2):  begin w_code = C_SRL; w_shamt = 1'b1; end
                FUNCT_W'(3):  begin w_code = C_SRA; w_shamt = 1'b1; end
                FUNCT_W'(8):  begin w_code = C_ADD; w_jr = 1'b1; end
                FUNCT_W'(24):               w_code = C_MUL;
                default:                    w_ill = 1'b1;
            endcase
        end else begin
            case (ALUOp_i)
                OP_W'(1), OP_W'(3): w_code = C_ADD;
                OP_W'(2):           w_code = C_SUB;
                OP_W'(4):           w_code = C_SLT;
                OP_W'(6):           w_code = C_OR;
                OP_W'(7):           w_code = C_LUI;
                default:            w_code = C_AND;
            endcase
        end
    end

    // pipeline register and multiply sequencer; reset beats flush beats accept
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            ALUCtrl_o   <= '0;
            valid_o     <= 1'b0;
            shamt_sel_o <= 1'b0;
            jr_o        <= 1'b0;
            illegal_o   <= 1'b0;
            mul_step_o  <= 1'b0;
            busy_o      <= 1'b0;
        end else if (flush_i) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            valid_o    <= 1'b0;
            mul_step_o <= 1'b0;
            busy_o     <= 1'b0;
        end else if (r_state == RUN) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
            if (r_cnt == LAST) begin
                r_state    <= DONE;
                valid_o    <= 1'b1;
                mul_step_o <= 1'b0;
                busy_o     <= 1'b0;
            end
        end else if (!stall_i) begin
            r_cnt <= '0;
            if (valid_i) begin
                r_state     <= w_mul ? RUN : IDLE;
                ALUCtrl_o   <= CTRL_W'(w_code);
                shamt_sel_o <= w_shamt;
                jr_o        <= w_jr;
                illegal_o   <= w_ill;
                valid_o     <= !w_mul;
                mul_step_o  <= w_mul;
                busy_o      <= w_mul;
            end else begin
                r_state    <= IDLE;
                valid_o    <= 1'b0;
                mul_step_o <= 1'b0;
                busy_o     <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// tb_alu_ctrl_pipe: directed and random checks of alu_ctrl_pipe against a cycle-level reference
module tb_alu_ctrl_pipe;
    localparam int MC = 4;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0, valid_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
    logic [5:0] funct_i = '0;
    logic [2:0] ALUOp_i = '0;
    logic       ready_o, valid_o, shamt_sel_o, jr_o, illegal_o, mul_step_o, busy_o;
    logic [3:0] ALUCtrl_o;

    int checks = 0, errors = 0;
    int mul_left = 0;
    bit started = 0, known = 0;
    logic       e_valid = 0, e_busy = 0, e_step = 0, e_sh = 0, e_jr = 0, e_ill = 0;
    logic [3:0] e_ctrl = '0;
    logic [3:0] op_tbl [8] = '{4'd0, 4'd2, 4'd6, 4'd2, 4'd7, 4'd0, 4'd1, 4'd8};
    int         fpool [17] = '{0, 2, 3, 8, 24, 32, 33, 34, 35, 36, 37, 39, 42, 43, 50, 1, 63};

    always #5 clk = ~clk;

    alu_ctrl_pipe #(.FUNCT_W(6), .OP_W(3), .CTRL_W(4), .MUL_CYCLES(MC)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .funct_i(funct_i),
        .ALUOp_i(ALUOp_i), .stall_i(stall_i), .flush_i(flush_i), .ALUCtrl_o(ALUCtrl_o),
        .valid_o(valid_o), .shamt_sel_o(shamt_sel_o), .jr_o(jr_o), .illegal_o(illegal_o),
        .mul_step_o(mul_step_o), .busy_o(busy_o)
    );

    function automatic logic [6:0] ref_dec(input logic [2:0] op, input logic [5:0] f);
        logic [3:0] c;
        logic sh, jr, ill;
        c = 4'd0; sh = 1'b0; jr = 1'b0; ill = 1'b0;
        if (op != 3'd0) c = op_tbl[op];
        else case (f)
            32, 33: c = 4'd2;
            34, 35: c = 4'd6;
            36:     c = 4'd0;
            37:     c = 4'd1;
            39:     c = 4'd12;
            42:     c = 4'd7;
            43:     c = 4'd10;
            0:      begin c = 4'd3; sh = 1'b1; end
            2:      begin c = 4'd4; sh = 1'b1; end
            3:      begin c = 4'd5; sh = 1'b1; end
            8:      begin c = 4'd2; jr = 1'b1; end
            24:     c = 4'd9;
            default: ill = 1'b1;
        endcase
        return {ill, jr, sh, c};
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc(input bit r, input bit v, input int op, input int f, input bit s, input bit fl);
        logic [6:0] d;
        @(negedge clk);
        rst_i = r; valid_i = v; ALUOp_i = op[2:0]; funct_i = f[5:0]; stall_i = s; flush_i = fl;
        #1;
        if (r && started) chk("ready", {3'b0, ready_o}, {3'b0, !s && mul_left == 0});
        d = ref_dec(op[2:0], f[5:0]);
        if (!r) begin
            e_valid = 0; e_busy = 0; e_step = 0; e_sh = 0; e_jr = 0; e_ill = 0; e_ctrl = '0;
            mul_left = 0; known = 1; started = 1;
        end else if (fl) begin
            e_valid = 0; e_busy = 0; e_step = 0; mul_left = 0; known = 0;
        end else if (mul_left > 0) begin
            mul_left--;
            if (mul_left == 0) begin e_valid = 1; e_busy = 0; e_step = 0; end
        end else if (!s) begin
            if (v) begin
                known = 1; e_ctrl = d[3:0]; e_sh = d[4]; e_jr = d[5]; e_ill = d[6];
                if (d[3:0] == 4'd9) begin mul_left = MC; e_valid = 0; e_busy = 1; e_step = 1; end
                else begin e_valid = 1; e_busy = 0; e_step = 0; end
            end else begin
                e_valid = 0; e_busy = 0; e_step = 0;
            end
        end
        @(posedge clk);
        #1;
        if (started) begin
            chk("valid", {3'b0, valid_o}, {3'b0, e_valid});
            chk("busy", {3'b0, busy_o}, {3'b0, e_busy});
            chk("mul_step", {3'b0, mul_step_o}, {3'b0, e_step});
        end
        if (started && known) begin
            chk("ctrl", ALUCtrl_o, e_ctrl);
            chk("shamt_sel", {3'b0, shamt_sel_o}, {3'b0, e_sh});
            chk("jr", {3'b0, jr_o}, {3'b0, e_jr});
            chk("illegal", {3'b0, illegal_o}, {3'b0, e_ill});
        end
    endtask

    initial begin
        cyc(0, 1, 0, 32, 0, 0);
        cyc(0, 1, 0, 32, 0, 0);
        cyc(1, 1, 0, 32, 0, 0);
        foreach (fpool[i]) cyc(1, 1, 0, fpool[i], 0, 0);
        for (int op = 1; op < 8; op++) cyc(1, 1, op, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 24, 0, 0);
        for (int i = 0; i < MC; i++) cyc(1, 1, 0, 32, 0, 0);
        cyc(1, 1, 0, 24, 0, 0);
        for (int i = 0; i < MC; i++) cyc(1, 1, 0, 32, 1, 0);
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 32, 1, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 24, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 32, 0, 1);
        cyc(1, 1, 0, 24, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 1, 2, 0, 0, 0);
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(39, 0) != 0, $urandom_range(3, 0) != 0,
                ($urandom_range(1, 0) != 0) ? 0 : int'($urandom_range(7, 0)),
                fpool[$urandom_range(16, 0)], $urandom_range(3, 0) == 0,
                $urandom_range(14, 0) == 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_ctrl_pipe.md
Name: alu_ctrl_pipe

Overview:
Registered, parametrised ALU control stage for the pipelined MIPS datapath. It sits between ID/EX and the ALU. It decodes ALUOp/funct into an extended ALU control code covering shifts, nor, sltu, lui and jr. It also sequences multi-cycle multiply (mult) with a counter and a valid/ready/stall handshake.

Parameters:
FUNCT_W, 6, width of funct field
OP_W, 3, width of ALUOp field
CTRL_W, 4, width of ALU control code (minimum 4)
MUL_CYCLES, 32, cycles an accepted mult occupies the ALU (must be at least 2)

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  reset, synchronous, active-low
valid_i  in  1  upstream instruction valid
ready_o  out  1  stage can accept this cycle
funct_i  in  FUNCT_W  instruction funct field
ALUOp_i  in  OP_W  main-control ALU operation class
stall_i  in  1  downstream hold request
flush_i  in  1  squash stage contents (branch/jump redirect)
ALUCtrl_o  out  CTRL_W  registered ALU control code
valid_o  out  1  ALUCtrl_o is a live, completed instruction
shamt_sel_o  out  1  ALU operand A is shamt (sll/srl/sra)
jr_o  out  1  current instruction is jr
illegal_o  out  1  undefined R-type funct
mul_step_o  out  1  multiplier iterate strobe
busy_o  out  1  multiply in progress

Behaviour:
- Control codes: AND 0000, OR 0001, ADD 0010, SLL 0011, SRL 0100, SRA 0101, SUB 0110, SLT 0111, LUI 1000, MUL 1001, SLTU 1010, NOR 1100. Zero-extend to CTRL_W.
- ALUOp decode: 0 = R-type (by funct); 1 = ADD; 2 = SUB; 3 = ADD; 4 = SLT; 5 = AND; 6 = OR; 7 = LUI.
- R-type funct decode: 32 and 33 = ADD; 34 and 35 = SUB; 36 = AND; 37 = OR; 39 = NOR; 42 = SLT; 43 = SLTU.
- Shift funct: 0 = SLL, 2 = SRL, 3 = SRA, each with shamt_sel_o=1.
- Other R-type funct: 8 = ADD with jr_o=1; 24 = MUL.
- Any other R-type funct: AND, illegal_o=1.
- Reset (rst_i=0 at edge): state IDLE, counter 0, ALUCtrl_o=0, valid_o=0, shamt_sel_o=0, jr_o=0, illegal_o=0, mul_step_o=0, busy_o=0. Reset overrides everything.
- ready_o = !stall_i && state!=RUN (combinational).
- Accept = valid_i && ready_o. All decoded outputs register on accept; latency is 1 cycle.
- Non-MUL accept in cycle N: valid_o=1 in N+1.
- Accept cycle with no valid_i: valid_o=0 next cycle (bubble).
- FSM states: IDLE, RUN, DONE.
- IDLE: accept of MUL -> RUN, counter cleared. Otherwise stay in IDLE.
- RUN: valid_o=0, busy_o=1, mul_step_o=1, ALUCtrl_o=MUL.
  - Counter increments every cycle, stall_i ignored.
  - When counter==MUL_CYCLES-1 -> DONE.
  - MUL accepted in N gives RUN in cycles N+1..N+MUL_CYCLES.
- DONE: valid_o=1, busy_o=0, mul_step_o=0 (cycle N+MUL_CYCLES+1).
  - While stall_i=1: hold all outputs.
  - When stall_i=0: accept a new instruction as in IDLE (back-to-back MUL re-enters RUN), else go to IDLE with valid_o=0.
- stall_i=1 in IDLE: all outputs hold; no accept.
- flush_i=1: next cycle valid_o=0, busy_o=0, mul_step_o=0, state IDLE, counter 0. ALUCtrl_o may hold.
  - Priority: rst_i > flush_i > accept. A same-cycle accept is dropped.
- Counter width: clog2(MUL_CYCLES). Counter never wraps; it exits at MUL_CYCLES-1.

Test Plan:
- Reset: hold rst_i=0 for 2 cycles with valid_i=1, ALUOp_i=0, funct_i=32 -> all outputs 0, no accept. Release -> next edge ALUCtrl_o=0010, valid_o=1.
- Decode sweep: ALUOp_i=0 with funct 0, 2, 3, 8, 39, 43, 50 -> ALUCtrl_o 0011/0100/0101/0010/1100/1010/0000. shamt_sel_o=1 for the first three, jr_o=1 for funct 8, illegal_o=1 for funct 50. ALUOp_i 1..7 -> 0010, 0110, 0010, 0111, 0000, 0001, 1000.
- Multiply with MUL_CYCLES=4: accept funct 24 at cycle 10.
  - Cycles 11-14: busy_o=1, mul_step_o=1, ready_o=0, valid_o=0.
  - Cycle 15: valid_o=1, ALUCtrl_o=1001.
  - A second mult offered at cycle 15 is accepted: RUN again in cycles 16-19.
- Stall: assert stall_i in DONE for 3 cycles -> outputs frozen, ready_o=0. stall_i during RUN -> counter still completes in MUL_CYCLES.
- Flush: flush_i at cycle 12 of a 4-cycle mult -> cycle 13: IDLE, busy_o=0, valid_o=0. flush_i together with an accept -> valid_o=0 next cycle.
- Mid-RUN reset: rst_i=0 during RUN -> next edge returns to the reset values; the following accept works normally.
